light_sequence_monitor: RTL
===========================

Name: light_sequence_monitor

Overview:
- Passive checker on the far end of the traffic-light output bus.
- Samples the four 3-bit light buses every clock and decodes them into a phase number.
- Locks onto the six-phase cycle and checks order, dwell time and legality of every light pattern.
- Reports errors and the lock status, and counts completed cycles.
- Used in simulation benches and as an on-chip safety watchdog beside the light controller.

Parameters:
- DWELL_P0, 8, required cycles in phase 0 (M1 G, M2 G, MT R, S R)
- DWELL_P1, 3, required cycles in phase 1 (M1 G, M2 Y, MT R, S R)
- DWELL_P2, 6, required cycles in phase 2 (M1 G, M2 R, MT G, S R)
- DWELL_P3, 3, required cycles in phase 3 (M1 Y, M2 R, MT Y, S R)
- DWELL_P4, 4, required cycles in phase 4 (M1 R, M2 R, MT R, S G)
- DWELL_P5, 3, required cycles in phase 5 (M1 R, M2 R, MT R, S Y)
- CNT_W, 16, width of cycle_count

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-low (0 = reset)
- light_M1  in  3  main road 1 light; 001 green, 010 yellow, 100 red
- light_S  in  3  side road light, same encoding
- light_MT  in  3  main-turn light, same encoding
- light_M2  in  3  main road 2 light, same encoding
- err_clr  in  1  clears err_sticky
- phase  out  3  decoded phase of the last sampled pattern, 0-5; 7 = invalid
- locked  out  1  monitor is in TRACK state
- err_pulse  out  1  one-cycle strobe per detected error
- err_code  out  2  last error: 00 none, 01 illegal, 10 sequence, 11 dwell
- err_sticky  out  1  set by any error, held until err_clr
- cycle_count  out  CNT_W  completed phase-5 -> phase-0 transitions while locked, wraps

Behaviour:
- All outputs are registered and reflect the pattern sampled at the same edge (one-cycle latency).
- Reset (rst=0 at an edge): phase=7, prev_phase=7, locked=0, err_pulse=0, err_code=00, err_sticky=0, cycle_count=0, dwell=0, state=SYNC. Reset mid-cycle discards all tracking.
- Decode: a pattern is valid only when it exactly equals one of the six phases listed under Parameters. Any non-one-hot field or any other combination is illegal (phase=7).
- State machine (2 states):
  - SYNC:
    - Illegal pattern -> err_pulse, err_code=01.
    - Valid pattern that differs from a valid prev_phase -> TRACK, cur=new phase, dwell=1.
    - Otherwise stay in SYNC. This means no dwell checking on the partial first phase after reset or error.
  - TRACK (locked=1): per cycle, in priority order:
    - illegal pattern -> err 01;
    - else phase change to anything other than (cur+1) mod 6 -> err 10;
    - else phase change with dwell != DWELL[cur] -> err 11;
    - else phase unchanged and dwell == DWELL[cur] -> err 11 (overrun, flagged on the first extra cycle);
    - else phase change -> cur=next, dwell=1, and increment cycle_count if cur was 5;
    - else dwell+1.
  - Any error in TRACK -> SYNC, locked=0, dwell=0. The erroneous pattern becomes prev_phase, so relock happens on the next valid change.
- dwell is 8 bits and saturates at 255; DWELL_Px values are limited to 1..254.
- err_sticky: set on any err_pulse. If err_clr and a new error occur in the same cycle, set wins. err_clr never changes err_code.
- At most one error per cycle; err_code holds the highest-priority error.
- cycle_count wraps from 2^CNT_W-1 to 0.

Test Plan:
- Nominal: reset, then drive 4 full cycles with dwells 8/3/6/3/4/3 (27 clk per cycle) -> locked rises after the first phase change, err_pulse never set, cycle_count = number of 5->0 transitions seen while locked (3 or 4 depending on entry phase).
- Illegal: while locked, drive M2=001 and MT=001 for 1 cycle -> next edge phase=7, err_pulse=1, err_code=01, locked=0, err_sticky=1.
- Short and long dwell: phase 0 held 5 cycles then phase 1 -> err_code=11 on the change cycle. Phase 0 held 9 cycles -> err_code=11 on the 9th sampled cycle.
- Sequence skip: locked in phase 0 with correct dwell, then phase 2 -> err_code=10, locked=0. Relock after the next valid change (2->3), with no error raised in between.
- err_clr collision: error and err_clr asserted on the same edge -> err_sticky stays 1. err_clr alone on the next edge -> err_sticky=0, err_code unchanged.
- Mid-run reset: rst=0 for 1 cycle during phase 3 -> all outputs at reset values. Next cycle in SYNC, no dwell error on the partial phase 3, locked again after the 3->4 change.

Source files
------------

// File: rtl/light_sequence_monitor.sv
// Passive traffic-light sequence checker: decodes phase, locks onto the 6-phase cycle, flags order/dwell/illegal errors.
// Latency: one cycle, all outputs registered; no backpressure, the bus is sampled every clock.
module light_sequence_monitor #(
    parameter int DWELL_P0 = 8,
    parameter int DWELL_P1 = 3,
    parameter int DWELL_P2 = 6,
    parameter int DWELL_P3 = 3,
    parameter int DWELL_P4 = 4,
    parameter int DWELL_P5 = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       light_M1,
    input  logic [2:0]       light_S,
    input  logic [2:0]       light_MT,
    input  logic [2:0]       light_M2,
    input  logic             err_clr,
    output logic [2:0]       phase,
    output logic             locked,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic             err_sticky,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic {SYNC, TRACK} state_t;

    localparam logic [2:0] LG = 3'b001;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LR = 3'b100;
    localparam logic [2:0] PH_INV = 3'd7;
    localparam logic [1:0] E_ILLEGAL = 2'b01;
    localparam logic [1:0] E_SEQ     = 2'b10;
    localparam logic [1:0] E_DWELL   = 2'b11;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state_q, state_d;
    logic [2:0] cur_q, cur_d;
    logic [2:0] prev_q;
    logic [2:0] dec;
    logic [2:0] nxt;
    logic [7:0] dwell_q, dwell_d;
    logic [7:0] dwell_req;
    logic       err_d;
    logic [1:0] code_d;
    logic       cnt_inc;

    always_comb begin
        dec = PH_INV;
        case ({light_M1, light_M2, light_MT, light_S})
            {LG, LG, LR, LR}: dec = 3'd0;
            {LG, LY, LR, LR}: dec = 3'd1;
            {LG, LR, LG, LR}: dec = 3'd2;
            {LY, LR, LY, LR}: dec = 3'd3;
            {LR, LR, LR, LG}: dec = 3'd4;
            {LR, LR, LR, LY}: dec = 3'd5;
            default:          dec = PH_INV;
        endcase
    end

    always_comb begin
        dwell_req = 8'(DWELL_P0);
        case (cur_q)
            3'd0:    dwell_req = 8'(DWELL_P0);
            3'd1:    dwell_req = 8'(DWELL_P1);
            3'd2:    dwell_req = 8'(DWELL_P2);
            3'd3:    dwell_req = 8'(DWELL_P3);
            3'd4:    dwell_req = 8'(DWELL_P4);
            default: dwell_req = 8'(DWELL_P5);
        endcase
    end

    assign nxt = (cur_q == 3'd5) ? 3'd0 : cur_q + 3'd1;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        dwell_d = dwell_q;
        err_d   = 1'b0;
        code_d  = 2'b00;
        cnt_inc = 1'b0;
        case (state_q)
            SYNC: begin
                dwell_d = 8'd0;
                if (dec == PH_INV) begin
                    err_d  = 1'b1;
                    code_d = E_ILLEGAL;
                end else if (prev_q != PH_INV && dec != prev_q) begin
                    state_d = TRACK;
                    cur_d   = dec;
                    dwell_d = 8'd1;
                end
            end
            TRACK: begin
                if (dec == PH_INV) begin
                    err_d  = 1'b1;
                    code_d = E_ILLEGAL;
                end else if (dec != cur_q && dec != nxt) begin
                    err_d  = 1'b1;
                    code_d = E_SEQ;
                end else if (dec != cur_q && dwell_q != dwell_req) begin
                    err_d  = 1'b1;
                    code_d = E_DWELL;
                end else if (dec == cur_q && dwell_q == dwell_req) begin
                    // overrun is flagged on the first cycle past the required dwell
                    err_d  = 1'b1;
                    code_d = E_DWELL;
                end else if (dec != cur_q) begin
                    cur_d   = dec;
                    dwell_d = 8'd1;
                    cnt_inc = (cur_q == 3'd5);
                end else if (dwell_q != 8'hFF) begin
                    dwell_d = dwell_q + 8'd1;
                end
            end
            default: state_d = SYNC;
        endcase
        if (err_d) begin
            state_d = SYNC;
            dwell_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= SYNC;
            cur_q       <= 3'd0;
            dwell_q     <= 8'd0;
            prev_q      <= PH_INV;
            err_pulse   <= 1'b0;
            err_code    <= 2'b00;
            err_sticky  <= 1'b0;
            cycle_count <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            dwell_q   <= dwell_d;
            prev_q    <= dec;
            err_pulse <= err_d;
            if (err_d) begin
                err_code <= code_d;
            end
            if (err_d) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
            if (cnt_inc) begin
                cycle_count <= cycle_count + CNT_ONE;
            end
        end
    end

    assign phase  = prev_q;
    assign locked = (state_q == TRACK);

endmodule
